alu_seq: RTL and testbench

- Parametrised, handshaked successor to the execute-stage integer ALU.
- Adds XLEN generalisation, a registered result with valid/ready flow control, and an iterative multi-cycle multiplier (MUL/MULHU).
- Sits in the EX stage between the operand mux and the EX/MEM register; the pipeline stalls on IN_READY low.

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage integer ALU with a registered result and
// an iterative shift-add multiplier (MUL low half, MULHU high half).
// Optional macro ALU_FLAGS_EN adds the registered {Z,N,C,V} FLAGS output.
// Ports:
//   CLK, RSTn            clock (rising edge), async active-low reset
//   IN_VALID/IN_READY    operation handshake (IN_READY is combinational)
//   ALUOP, SRC1, SRC2    opcode and operands
//   OUT_VALID/OUT_READY  result handshake
//   ALUOUT               registered result
//   FLAGS                registered {Z,N,C,V} (ALU_FLAGS_EN only)
module alu_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [3:0]      ALUOP,
    input  logic [XLEN-1:0] SRC1,
    input  logic [XLEN-1:0] SRC2,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] ALUOUT
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]      FLAGS
`endif
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;
`ifdef ALU_FLAGS_EN
    localparam int unsigned AW  = XLEN + 1;   // keep carry-out for C flag
`else
    localparam int unsigned AW  = XLEN;
`endif

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t              r_state;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_aluout;
    logic [XLEN-1:0]     r_mcand;
    logic [2*XLEN-1:0]   r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_hi;

    logic                w_accept;
    logic                w_is_mul;
    logic [SHW-1:0]      w_shamt;
    logic [CW-1:0]       w_lamt;
    logic [AW-1:0]       w_add;
    logic [AW-1:0]       w_sub;
    logic [XLEN-1:0]     w_res;
    logic [XLEN:0]       w_psum;
    logic [2*XLEN-1:0]   w_acc_nxt;
    logic [XLEN-1:0]     w_mul_res;

    // Handshake: only idle and with an empty or draining output slot.
    assign IN_READY  = (r_state == S_IDLE) && (!r_out_valid || OUT_READY);
    assign w_accept  = IN_VALID && IN_READY;
    assign w_is_mul  = (ALUOP == 4'd13) || (ALUOP == 4'd14);
    assign OUT_VALID = r_out_valid;
    assign ALUOUT    = r_aluout;

    // Shift amount uses only the low SHW bits; w_lamt is the complementary left
    // shift for rotate, equal to XLEN (all bits shifted out) when amount is 0.
    assign w_shamt = SRC2[SHW-1:0];
    assign w_lamt  = CW'(XLEN) - {1'b0, w_shamt};
    assign w_add   = AW'(SRC1) + AW'(SRC2);
    assign w_sub   = AW'(SRC1) + AW'(~SRC2) + AW'(1);

    // Single-cycle result.
    always_comb begin
        w_res = '0;
        case (ALUOP)
            4'd1:    w_res = w_add[XLEN-1:0];
            4'd2:    w_res = w_sub[XLEN-1:0];
            4'd3:    w_res = '0 - SRC2;
            4'd4:    w_res = ~SRC2;
            4'd5:    w_res = SRC1 & SRC2;
            4'd6:    w_res = SRC1 | SRC2;
            4'd7:    w_res = SRC1 ^ SRC2;
            4'd8:    w_res = SRC1 >> w_shamt;
            4'd9:    w_res = $signed(SRC1) >>> w_shamt;
            4'd10:   w_res = SRC1 << w_shamt;
            4'd11:   w_res = (SRC1 >> w_shamt) | (SRC1 << w_lamt);
            4'd12:   w_res = SRC2;
            default: w_res = '0;
        endcase
    end

    // Shift-add step: upper half accumulates, lower half holds the remaining
    // multiplier bits, whose LSB selects the add; whole register shifts right.
    assign w_psum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = {w_psum, r_acc[XLEN-1:1]};
    assign w_mul_res = r_hi ? w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0];

`ifdef ALU_FLAGS_EN
    logic [3:0] r_flags;
    logic       w_c;
    logic       w_v;
    localparam int unsigned MSB = XLEN - 1;

    assign FLAGS = r_flags;

    // Carry / signed overflow only meaningful for add and sub.
    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        if (ALUOP == 4'd1) begin
            w_c = w_add[XLEN];
            w_v = (SRC1[MSB] == SRC2[MSB]) && (w_add[MSB] != SRC1[MSB]);
        end else if (ALUOP == 4'd2) begin
            w_c = w_sub[XLEN];
            w_v = (SRC1[MSB] != SRC2[MSB]) && (w_sub[MSB] != SRC1[MSB]);
        end
    end
`endif

    // Control FSM and result registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_aluout    <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_hi        <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_flags     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state     <= S_MUL;
                        r_mcand     <= SRC1;
                        r_acc       <= {{XLEN{1'b0}}, SRC2};
                        r_hi        <= (ALUOP == 4'd14);
                        r_cnt       <= CW'(XLEN);
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_aluout    <= w_res;
                        r_out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                        r_flags     <= {(w_res == '0), w_res[XLEN-1], w_c, w_v};
`endif
                    end else if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state     <= S_IDLE;
                        r_aluout    <= w_mul_res;
                        r_out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                        r_flags     <= {(w_mul_res == '0), w_mul_res[XLEN-1], 2'b00};
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (XLEN=32): directed plan items plus random ops
// with random output backpressure, checked against a behavioural model.
module tb_alu_seq;

    localparam int XL = 32;

    typedef struct {
        logic [XL-1:0] res;
        logic [3:0]    fl;
        int            due;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          IN_VALID;
    logic          IN_READY;
    logic [3:0]    ALUOP;
    logic [XL-1:0] SRC1;
    logic [XL-1:0] SRC2;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [XL-1:0] ALUOUT;
`ifdef ALU_FLAGS_EN
    logic [3:0]    FLAGS;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rnd   = 1'b0;
    exp_t q[$];

    alu_seq #(.XLEN(XL)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ALUOP     (ALUOP),
        .SRC1      (SRC1),
        .SRC2      (SRC2),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ALUOUT    (ALUOUT)
`ifdef ALU_FLAGS_EN
        ,
        .FLAGS     (FLAGS)
`endif
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model from the opcode definitions, plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic [XL-1:0] a,
                                  input logic [XL-1:0] b, output logic [XL-1:0] r,
                                  output logic [3:0] f);
        logic          c;
        logic          v;
        int            n;
        longint        sa;
        longint        sb;
        logic [63:0]   p;
        c  = 1'b0;
        v  = 1'b0;
        n  = int'(b % XL);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(a) * 64'(b);
        case (op)
            4'd1: begin
                r = a + b;
                c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                v = (sa + sb > 64'sd2147483647) || (sa + sb < -64'sd2147483648);
            end
            4'd2: begin
                r = a - b;
                c = (a >= b);
                v = (sa - sb > 64'sd2147483647) || (sa - sb < -64'sd2147483648);
            end
            4'd3:  r = -b;
            4'd4:  r = ~b;
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8:  r = a >> n;
            4'd9:  r = XL'(sa >>> n);
            4'd10: r = a << n;
            4'd11: begin
                r = a;
                for (int k = 0; k < n; k++) r = {r[0], r[XL-1:1]};
            end
            4'd12: r = b;
            4'd13: r = p[31:0];
            4'd14: r = p[63:32];
            default: r = '0;
        endcase
        f = {(r == '0), r[XL-1], c, v};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one op (called at posedge+1); returns at posedge+1 after the accept.
    task automatic issue(input logic [3:0] op, input logic [XL-1:0] a,
                         input logic [XL-1:0] b, input bit push);
        exp_t e;
        IN_VALID = 1'b1;
        ALUOP    = op;
        SRC1     = a;
        SRC2     = b;
        for (int t = 0; ; t++) begin
            @(negedge CLK);
            if (IN_READY) break;
            if (t > 300) begin
                total++;
                bad++;
                $display("FAIL accept_timeout op=%0d got IN_READY=0 expected 1", op);
                IN_VALID = 1'b0;
                return;
            end
            step();
            if (rnd) OUT_READY = 1'($urandom_range(0, 1));
        end
        if (push) begin
            model(op, a, b, e.res, e.fl);
            e.due = cyc + 1 + ((op == 4'd13 || op == 4'd14) ? XL : 0);
            q.push_back(e);
        end
        step();
        IN_VALID = 1'b0;
    endtask

    // Monitor: latency, result, flags and hold stability.
    initial begin
        bit            seen;
        bit            held_v;
        logic [XL-1:0] held;
        exp_t          e;
        seen   = 1'b0;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                seen   = 1'b0;
                held_v = 1'b0;
                continue;
            end
            if (held_v && OUT_VALID) chk("hold", ALUOUT, held);
            if (OUT_VALID) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result got %h expected none", ALUOUT);
                end else begin
                    if (!seen) begin
                        chk("latency", XL'(cyc), XL'(q[0].due));
                        seen = 1'b1;
                    end
                    if (OUT_READY) begin
                        e = q.pop_front();
                        chk("result", ALUOUT, e.res);
`ifdef ALU_FLAGS_EN
                        chk("flags", XL'(FLAGS), XL'(e.fl));
`endif
                        seen   = 1'b0;
                        held_v = 1'b0;
                    end else begin
                        held   = ALUOUT;
                        held_v = 1'b1;
                    end
                end
            end else begin
                held_v = 1'b0;
                if (q.size() > 0 && cyc > q[0].due) begin
                    total++;
                    bad++;
                    $display("FAIL late_result got nothing expected %h by cycle %0d", q[0].res, q[0].due);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [XL-1:0] corner[5];
        logic [XL-1:0] a;
        logic [XL-1:0] b;
        logic [3:0]    op;
        corner[0] = 32'h0;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        corner[4] = 32'h1;

        RSTn = 1'b0; IN_VALID = 1'b0; ALUOP = '0; SRC1 = '0; SRC2 = '0; OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", XL'(OUT_VALID), 0);
        chk("rst_aluout", ALUOUT, 0);
        step();
        RSTn = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", XL'(IN_READY), 1);

        // Reset in the middle of a multiply: no result may ever appear.
        step();
        issue(4'd13, 32'h3, 32'h5, 1'b0);
        repeat (8) step();
        RSTn = 1'b0;
        @(negedge CLK);
        chk("midmul_out_valid", XL'(OUT_VALID), 0);
        chk("midmul_aluout", ALUOUT, 0);
        step();
        RSTn = 1'b1;
        @(negedge CLK);
        chk("midmul_in_ready", XL'(IN_READY), 1);
        repeat (40) begin
            @(negedge CLK);
            chk("midmul_no_result", XL'(OUT_VALID), 0);
        end

        // Single-cycle ops back-to-back with OUT_READY held high.
        step();
        issue(4'd1,  32'h7FFF_FFFF, 32'h1,  1'b1);
        issue(4'd2,  32'h5,         32'h5,  1'b1);
        issue(4'd9,  32'h8000_0000, 32'd31, 1'b1);
        issue(4'd11, 32'h1234_5678, 32'd0,  1'b1);
        issue(4'd11, 32'h1234_5678, 32'd4,  1'b1);
        issue(4'd10, 32'h1,         32'h21, 1'b1);
        issue(4'd15, 32'hDEAD_BEEF, 32'h1,  1'b1);
        issue(4'd8,  32'hF000_0000, 32'hFFFF_FFE4, 1'b1);
        step();

        // MUL / MULHU: unit busy for the whole iteration.
        issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        repeat (XL) begin
            @(negedge CLK);
            chk("mul_busy", XL'(IN_READY), 0);
        end
        step();
        issue(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        repeat (XL) begin
            @(negedge CLK);
            chk("mulhu_busy", XL'(IN_READY), 0);
        end
        step();
        step();

        // Backpressure then same-edge drain and refill.
        OUT_READY = 1'b0;
        issue(4'd1, 32'd2, 32'd3, 1'b1);
        repeat (5) begin
            @(negedge CLK);
            chk("bp_in_ready", XL'(IN_READY), 0);
            chk("bp_aluout", ALUOUT, 32'd5);
        end
        step();
        OUT_READY = 1'b1;
        issue(4'd7, 32'hF0, 32'hFF, 1'b1);
        chk("swap_out_valid", XL'(OUT_VALID), 1);
        @(negedge CLK);
        chk("swap_aluout", ALUOUT, 32'h0F);
        step();

        // Random ops with random output backpressure.
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : XL'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : XL'($urandom);
            OUT_READY = 1'($urandom_range(0, 1));
            issue(op, a, b, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                step();
                OUT_READY = 1'($urandom_range(0, 1));
            end
        end
        rnd = 1'b0;
        OUT_READY = 1'b1;
        for (int t = 0; q.size() > 0; t++) begin
            if (t > 200) begin
                total++;
                bad++;
                $display("FAIL drain_timeout got %0d pending expected 0", q.size());
                break;
            end
            @(negedge CLK);
        end
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
